duc: RTL and testbench



---
 rtl/duc_pkg.sv | 40 ++++
 rtl/duc_fifo.sv | 51 +++++
 rtl/duc.sv | 211 +++++++++++++++++++++
 tb/tb_duc.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/duc_pkg.sv
// Shared types and helpers for the fs/4 digital up-converter.
// Also used by the DDC output stage for rounding/saturation.
package duc_pkg;

  localparam int DUC_IN_W       = 20;
  localparam int DUC_OUT_W      = 12;
  localparam int DUC_SHIFT      = 8;
  localparam int DUC_FIFO_DEPTH = 4;
  localparam int DUC_PRF_WIDTH  = 4;

  typedef enum logic [1:0] {
    PH_I_POS = 2'd0,
    PH_Q_NEG = 2'd1,
    PH_I_NEG = 2'd2,
    PH_Q_POS = 2'd3
  } phase_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Round half-up, arithmetic shift, clip to a signed out_w range.
  function automatic logic signed [31:0] sat_round(
    input logic signed [31:0] y,
    input int                 shift,
    input int                 out_w
  );
    logic signed [31:0] r;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    r  = (y + (32'sd1 <<< (shift - 1))) >>> shift;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (out_w - 1));
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage

// File: rtl/duc_fifo.sv
// Small synchronous FIFO feeding the up-converter.
// Push when full and pop when empty are both ignored.
module duc_fifo #(
  parameter int W     = 41,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_data,
  output logic [W-1:0]               o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/duc.sv
// fs/4 digital up-converter: x4 linear interpolation, mix by
// +I,-Q,-I,+Q, round/saturate to a real DAC sample stream.
module duc
  import duc_pkg::*;
#(
  parameter int IN_W       = DUC_IN_W,
  parameter int OUT_W      = DUC_OUT_W,
  parameter int SHIFT      = DUC_SHIFT,
  parameter int FIFO_DEPTH = DUC_FIFO_DEPTH,
  parameter int PRF_WIDTH  = DUC_PRF_WIDTH
) (
  input  logic                    Clk_160,
  input  logic                    Rst,
  input  logic signed [IN_W-1:0]  Data_I_in,
  input  logic signed [IN_W-1:0]  Data_Q_in,
  input  logic                    Prf_in,
  input  logic                    In_valid,
  output logic                    In_ready,
  output logic signed [OUT_W-1:0] Data_out,
  output logic                    Out_valid,
  output logic                    Prf_out,
  output logic                    Underflow
);

  localparam int EW = 2 * IN_W + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int VW = IN_W + 3;
  localparam int PW = $clog2(PRF_WIDTH + 1);

  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_underflow;
  logic [EW-1:0]           w_head;
  logic [CW-1:0]           w_count;
  logic [CW-1:0]           w_count_nx;
  logic                    w_head_prf;
  logic signed [IN_W-1:0]  w_head_i;
  logic signed [IN_W-1:0]  w_head_q;

  state_t                  r_state;
  state_t                  w_state_nx;
  phase_t                  r_phase;
  logic                    r_in_ready;
  logic signed [IN_W-1:0]  r_prev_i;
  logic signed [IN_W-1:0]  r_prev_q;
  logic signed [IN_W-1:0]  r_cur_i;
  logic signed [IN_W-1:0]  r_cur_q;
  logic                    r_cur_prf;

  duc_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (Clk_160),
    .i_rst   (Rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({Prf_in, Data_I_in, Data_Q_in}),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_prf = w_head[EW-1];
  assign w_head_i   = w_head[EW-2 -: IN_W];
  assign w_head_q   = w_head[IN_W-1:0];
  assign w_push     = In_valid && r_in_ready;
  assign w_count_nx = w_count
                    + CW'(w_push && !w_full)
                    - CW'(w_pop && !w_empty);

  always_comb begin
    w_state_nx  = r_state;
    w_pop       = 1'b0;
    w_underflow = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_state_nx = RUN;
        end
      end
      RUN: begin
        if (r_phase == PH_Q_POS) begin
          if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_underflow = 1'b1;
            w_state_nx  = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk_160) begin
    if (Rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  always_ff @(posedge Clk_160) begin
    if (Rst) begin
      r_phase    <= PH_I_POS;
      r_in_ready <= 1'b0;
      r_prev_i   <= '0;
      r_prev_q   <= '0;
      r_cur_i    <= '0;
      r_cur_q    <= '0;
      r_cur_prf  <= 1'b0;
    end else begin
      r_in_ready <= (w_count_nx < CW'(FIFO_DEPTH));
      if (r_state == RUN) r_phase <= phase_t'(r_phase + 2'd1);
      else                r_phase <= PH_I_POS;
      if (w_pop) begin
        // a fresh start from IDLE ramps up from zero
        r_prev_i  <= (r_state == RUN) ? r_cur_i : '0;
        r_prev_q  <= (r_state == RUN) ? r_cur_q : '0;
        r_cur_i   <= w_head_i;
        r_cur_q   <= w_head_q;
        r_cur_prf <= w_head_prf;
      end else if (w_underflow) begin
        r_prev_i  <= '0;
        r_prev_q  <= '0;
        r_cur_i   <= '0;
        r_cur_q   <= '0;
        r_cur_prf <= 1'b0;
      end
    end
  end

  logic                   w_sel_i;
  logic signed [IN_W-1:0] w_p;
  logic signed [IN_W-1:0] w_c;
  logic signed [VW-1:0]   w_px;
  logic signed [VW-1:0]   w_cx;
  logic signed [VW-1:0]   w_d;
  logic signed [VW-1:0]   w_kd;
  logic signed [VW-1:0]   w_v;

  assign w_sel_i = ~r_phase[0];
  assign w_p     = w_sel_i ? r_prev_i : r_prev_q;
  assign w_c     = w_sel_i ? r_cur_i : r_cur_q;
  assign w_px    = {{3{w_p[IN_W-1]}}, w_p};
  assign w_cx    = {{3{w_c[IN_W-1]}}, w_c};
  assign w_d     = w_cx - w_px;

  always_comb begin
    w_kd = '0;
    unique case (r_phase)
      PH_I_POS: w_kd = '0;
      PH_Q_NEG: w_kd = w_d;
      PH_I_NEG: w_kd = w_d <<< 1;
      PH_Q_POS: w_kd = (w_d <<< 1) + w_d;
    endcase
  end

  assign w_v = w_px + (w_kd >>> 2);

  logic signed [VW-1:0] r_s1_v;
  logic                 r_s1_neg;
  logic                 r_s1_valid;
  logic                 r_s1_prf;

  always_ff @(posedge Clk_160) begin
    if (Rst) begin
      r_s1_v     <= '0;
      r_s1_neg   <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_prf   <= 1'b0;
    end else begin
      r_s1_v     <= w_v;
      r_s1_neg   <= (r_phase == PH_Q_NEG) || (r_phase == PH_I_NEG);
      r_s1_valid <= (r_state == RUN);
      r_s1_prf   <= (r_state == RUN) && (r_phase == PH_I_POS)
                 && r_cur_prf;
    end
  end

  logic signed [31:0]      w_vx;
  logic signed [31:0]      w_y;
  logic signed [OUT_W-1:0] r_data;
  logic                    r_out_valid;
  logic [PW-1:0]           r_prf_cnt;

  assign w_vx = {{(32-VW){r_s1_v[VW-1]}}, r_s1_v};
  assign w_y  = r_s1_neg ? -w_vx : w_vx;

  always_ff @(posedge Clk_160) begin
    if (Rst) begin
      r_data      <= '0;
      r_out_valid <= 1'b0;
      r_prf_cnt   <= '0;
    end else begin
      r_out_valid <= r_s1_valid;
      r_data      <= r_s1_valid
                   ? OUT_W'(sat_round(w_y, SHIFT, OUT_W)) : '0;
      if (r_s1_prf)              r_prf_cnt <= PW'(PRF_WIDTH);
      else if (r_prf_cnt != '0)  r_prf_cnt <= r_prf_cnt - 1'b1;
    end
  end

  assign In_ready  = r_in_ready;
  assign Data_out  = r_data;
  assign Out_valid = r_out_valid;
  assign Prf_out   = (r_prf_cnt != '0);
  assign Underflow = w_underflow;

endmodule

// File: tb/tb_duc.sv
// Directed bench for duc: reset, ramp/steady tone, saturation,
// backpressure, underflow, PRF alignment and mid-stream reset.
module tb_duc;

  localparam int IN_W  = 20;
  localparam int OUT_W = 12;

  logic                    Clk_160   = 1'b0;
  logic                    Rst       = 1'b1;
  logic signed [IN_W-1:0]  Data_I_in = '0;
  logic signed [IN_W-1:0]  Data_Q_in = '0;
  logic                    Prf_in    = 1'b0;
  logic                    In_valid  = 1'b0;
  logic                    In_ready;
  logic signed [OUT_W-1:0] Data_out;
  logic                    Out_valid;
  logic                    Prf_out;
  logic                    Underflow;

  int n_pass  = 0;
  int n_total = 0;

  duc #(
    .IN_W       (IN_W),
    .OUT_W      (OUT_W),
    .SHIFT      (8),
    .FIFO_DEPTH (4),
    .PRF_WIDTH  (4)
  ) dut (
    .Clk_160   (Clk_160),
    .Rst       (Rst),
    .Data_I_in (Data_I_in),
    .Data_Q_in (Data_Q_in),
    .Prf_in    (Prf_in),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .Data_out  (Data_out),
    .Out_valid (Out_valid),
    .Prf_out   (Prf_out),
    .Underflow (Underflow)
  );

  always #5 Clk_160 = ~Clk_160;

  task automatic tick();
    @(posedge Clk_160);
    #1;
  endtask

  task automatic idle_in();
    In_valid  = 1'b0;
    Prf_in    = 1'b0;
    Data_I_in = '0;
    Data_Q_in = '0;
  endtask

  task automatic apply_reset();
    idle_in();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    tick();
  endtask

  task automatic drive(input int i, input int q);
    In_valid  = 1'b1;
    Data_I_in = IN_W'(i);
    Data_Q_in = IN_W'(q);
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    drive(123, 456);
    tick();
    n_total++;
    if ({In_ready, Out_valid, Prf_out, Underflow} !== 4'b0000
        || Data_out !== '0)
      $display("FAIL reset_outs: rdy=%b ov=%b prf=%b uf=%b d=%0d, want all 0",
               In_ready, Out_valid, Prf_out, Underflow, Data_out);
    else n_pass++;
    idle_in();
    Rst = 1'b0;
    tick();
    n_total++;
    if (In_ready !== 1'b1 || Out_valid !== 1'b0)
      $display("FAIL reset_release: rdy=%b ov=%b, want 1/0",
               In_ready, Out_valid);
    else n_pass++;
  endtask

  task automatic test_ramp_steady();
    int exp_r [12];
    exp_r = '{0, -12, -50, 38, 100, -50, -100, 50,
              100, -50, -100, 50};
    apply_reset();
    drive(25600, 12800);
    tick(); tick(); tick();
    n_total++;
    if (Out_valid !== 1'b0)
      $display("FAIL ramp_early_valid: ov=%b, want 0", Out_valid);
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_total++;
      if (Out_valid !== 1'b1 || Data_out !== OUT_W'(exp_r[i]))
        $display("FAIL ramp[%0d]: d=%0d ov=%b, want %0d ov=1",
                 i, Data_out, Out_valid, exp_r[i]);
      else n_pass++;
    end
    idle_in();
  endtask

  task automatic test_saturation();
    int vi [2];
    int vq [2];
    int exp_s [8];
    vi    = '{-524288, 524287};
    vq    = '{524287, 524287};
    exp_s = '{-2048, -2048, 2047, 2047, 2047, -2048, -2048, 2047};
    for (int v = 0; v < 2; v++) begin
      apply_reset();
      drive(vi[v], vq[v]);
      for (int t = 0; t < 7; t++) tick();
      for (int k = 0; k < 4; k++) begin
        tick();
        n_total++;
        if (Out_valid !== 1'b1 || Data_out !== OUT_W'(exp_s[v*4+k]))
          $display("FAIL sat[%0d][%0d]: d=%0d ov=%b, want %0d",
                   v, k, Data_out, Out_valid, exp_s[v*4+k]);
        else n_pass++;
      end
      idle_in();
    end
  endtask

  task automatic test_backpressure();
    int  n;
    int  j;
    logic exp_rdy;
    logic acc;
    apply_reset();
    n = 1;
    drive(n * 4096, 0);
    for (int c = 0; c < 40; c++) begin
      exp_rdy = (c <= 4) || (c >= 6 && (c - 6) % 4 == 0);
      n_total++;
      if (In_ready !== exp_rdy)
        $display("FAIL bp_ready@%0d: rdy=%b, want %b",
                 c, In_ready, exp_rdy);
      else n_pass++;
      if (c >= 4 && (c - 4) % 4 == 0) begin
        j = (c - 4) / 4;
        n_total++;
        if (Out_valid !== 1'b1 || Data_out !== OUT_W'(16 * j))
          $display("FAIL bp_ph0[%0d]: d=%0d ov=%b, want %0d",
                   j, Data_out, Out_valid, 16 * j);
        else n_pass++;
      end
      if (c >= 6 && (c - 6) % 4 == 0) begin
        j = (c - 6) / 4;
        n_total++;
        if (Data_out !== OUT_W'(-16 * j - 8))
          $display("FAIL bp_ph2[%0d]: d=%0d, want %0d",
                   j, Data_out, -16 * j - 8);
        else n_pass++;
      end
      acc = In_valid && In_ready;
      tick();
      if (acc) begin
        n++;
        Data_I_in = IN_W'(n * 4096);
      end
    end
    idle_in();
  endtask

  task automatic test_underflow();
    apply_reset();
    drive(25600, 12800);
    for (int c = 0; c < 18; c++) begin
      n_total++;
      if (Underflow !== (c == 13))
        $display("FAIL uf_pulse@%0d: uf=%b, want %b",
                 c, Underflow, c == 13);
      else n_pass++;
      if (c == 15) begin
        n_total++;
        if (Out_valid !== 1'b1 || Data_out !== OUT_W'(50))
          $display("FAIL uf_last: d=%0d ov=%b, want 50 ov=1",
                   Data_out, Out_valid);
        else n_pass++;
      end
      if (c == 16) begin
        n_total++;
        if (Out_valid !== 1'b0 || Data_out !== '0)
          $display("FAIL uf_drop: d=%0d ov=%b, want 0 ov=0",
                   Data_out, Out_valid);
        else n_pass++;
      end
      tick();
      if (c == 2) idle_in();
    end
    drive(25600, 12800);
    tick(); tick(); tick();
    n_total++;
    if (Out_valid !== 1'b0)
      $display("FAIL uf_restart_early: ov=%b, want 0", Out_valid);
    else n_pass++;
    tick();
    n_total++;
    if (Out_valid !== 1'b1 || Data_out !== '0)
      $display("FAIL uf_restart_ph0: d=%0d ov=%b, want 0 ov=1",
               Data_out, Out_valid);
    else n_pass++;
    tick();
    n_total++;
    if (Data_out !== OUT_W'(-12))
      $display("FAIL uf_restart_ph1: d=%0d, want -12", Data_out);
    else n_pass++;
    idle_in();
  endtask

  task automatic test_prf_reset();
    int   acc_n;
    logic acc;
    logic exp_p;
    apply_reset();
    acc_n = 0;
    drive(25600, 12800);
    for (int c = 0; c < 37; c++) begin
      Prf_in = (acc_n == 4) || (acc_n == 8);
      if (c >= 16 && c <= 26) begin
        exp_p = (c >= 20 && c <= 23);
        n_total++;
        if (Prf_out !== exp_p)
          $display("FAIL prf_pulse@%0d: prf=%b, want %b",
                   c, Prf_out, exp_p);
        else n_pass++;
      end
      if (c == 20) begin
        n_total++;
        if (Out_valid !== 1'b1 || Data_out !== OUT_W'(100))
          $display("FAIL prf_data: d=%0d ov=%b, want 100 ov=1",
                   Data_out, Out_valid);
        else n_pass++;
      end
      if (c == 36) begin
        n_total++;
        if (Prf_out !== 1'b1)
          $display("FAIL prf_second: prf=%b, want 1", Prf_out);
        else n_pass++;
      end
      acc = In_valid && In_ready;
      tick();
      if (acc) acc_n++;
    end
    Rst = 1'b1;
    tick();
    n_total++;
    if ({In_ready, Out_valid, Prf_out, Underflow} !== 4'b0000
        || Data_out !== '0)
      $display("FAIL midrst_outs: rdy=%b ov=%b prf=%b uf=%b d=%0d, want all 0",
               In_ready, Out_valid, Prf_out, Underflow, Data_out);
    else n_pass++;
    idle_in();
    Rst = 1'b0;
    tick();
    n_total++;
    if (In_ready !== 1'b1)
      $display("FAIL midrst_ready: rdy=%b, want 1", In_ready);
    else n_pass++;
    for (int t = 0; t < 6; t++) begin
      tick();
      n_total++;
      if (Out_valid !== 1'b0 || Prf_out !== 1'b0)
        $display("FAIL midrst_quiet@%0d: ov=%b prf=%b, want 0/0",
                 t, Out_valid, Prf_out);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_ramp_steady();
    test_saturation();
    test_backpressure();
    test_underflow();
    test_prf_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
